// File: rtl/ps_ctrl_pkg.sv
// rtl/ps_ctrl_pkg.sv - shared types and constants for the dynamic phase-shift controller
//
// Purpose: holds the controller state encoding, the full-turn constant in
// thousandths of a degree and the settle counter width, so the top level and
// the wrap adder agree on them.
// Ports: none (package).

package ps_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } ps_state_t;

  localparam int FULL_TURN_1000 = 360000;
  localparam int CNT_W          = 8;

endpackage

// File: rtl/phase_wrap_add.sv
// rtl/phase_wrap_add.sv - combinational step adder with single-turn wrap
//
// Purpose: adds or subtracts one step to the current shift and folds the
// result back into -359999..359999.
// Ports:
//   cur    - current shift, thousandths of a degree (signed 32)
//   inc    - 1 adds STEP_1000, 0 subtracts it
//   result - stepped and wrapped shift (signed 32)

module phase_wrap_add
  import ps_ctrl_pkg::*;
#(
  parameter int STEP_1000 = 1000
) (
  input  logic signed [31:0] cur,
  input  logic               inc,
  output logic signed [31:0] result
);

  localparam logic signed [32:0] STEP_W = 33'(STEP_1000);
  localparam logic signed [32:0] TURN_W = 33'(FULL_TURN_1000);

  logic signed [32:0] cur_w;
  logic signed [32:0] raw;
  logic signed [32:0] wrapped;

  // |cur| and STEP are both below one turn, so |raw| stays below two turns
  // and one correction is always enough; 33 bits keeps the sum exact.
  always_comb begin
    cur_w = {cur[31], cur};
    raw   = inc ? (cur_w + STEP_W) : (cur_w - STEP_W);
    if (raw >= TURN_W) begin
      wrapped = raw - TURN_W;
    end else if (raw <= -TURN_W) begin
      wrapped = raw + TURN_W;
    end else begin
      wrapped = raw;
    end
    result = wrapped[31:0];
  end

endmodule

// File: rtl/dyn_phase_shift_ctrl.sv
// rtl/dyn_phase_shift_ctrl.sv - step/settle controller for a dynamic phase shifter
//
// Purpose: accepts single phase steps, updates the shift value immediately,
// then waits SETTLE_CYCLES before pulsing PSDONE. Requests arriving while a
// step is in flight, or without lock, are dropped and flagged on ps_err.
// Ports:
//   clk        - clock, rising edge
//   RST        - synchronous active-high reset (wins over PWRDWN)
//   PWRDWN     - synchronous power-down, forces idle, holds shift_1000
//   PSEN       - step request
//   PSINCDEC   - step direction, 1 = increment
//   lock_in    - datapath lock status, required to accept a step
//   shift_1000 - current shift, thousandths of a degree (signed 32)
//   PSDONE     - one-cycle completion pulse
//   busy       - step in progress
//   ps_err     - one-cycle pulse for a rejected request

module dyn_phase_shift_ctrl
  import ps_ctrl_pkg::*;
#(
  parameter int STEP_1000       = 1000,
  parameter int SETTLE_CYCLES   = 12,
  parameter int INIT_SHIFT_1000 = 0
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               PWRDWN,
  input  logic               PSEN,
  input  logic               PSINCDEC,
  input  logic               lock_in,
  output logic signed [31:0] shift_1000,
  output logic               PSDONE,
  output logic               busy,
  output logic               ps_err
);

  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic signed [31:0] INIT_SHIFT  = 32'(INIT_SHIFT_1000);

  ps_state_t          state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic signed [31:0] shift_q, shift_nx;
  logic signed [31:0] stepped;
  logic               done_nx, busy_nx, err_nx;

  phase_wrap_add #(
    .STEP_1000(STEP_1000)
  ) u_wrap (
    .cur   (shift_q),
    .inc   (PSINCDEC),
    .result(stepped)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shift_nx = shift_q;
    err_nx   = 1'b0;
    if (PWRDWN) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEN) begin
            if (lock_in) begin
              state_nx = SETTLE;
              cnt_nx   = SETTLE_LOAD;
              shift_nx = stepped;
            end else begin
              err_nx = 1'b1;
            end
          end
        end
        SETTLE: begin
          // lock_in is deliberately ignored here: a started step always completes
          err_nx = PSEN;
          if (cnt == '0) begin
            state_nx = DONE;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        DONE: begin
          err_nx   = PSEN;
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
    // Status flags are registered copies of what the next state will be,
    // so they line up with the state register and see no input directly.
    done_nx = (state_nx == DONE);
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      shift_q <= INIT_SHIFT;
      PSDONE  <= 1'b0;
      busy    <= 1'b0;
      ps_err  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      shift_q <= shift_nx;
      PSDONE  <= done_nx;
      busy    <= busy_nx;
      ps_err  <= err_nx;
    end
  end

  assign shift_1000 = shift_q;

endmodule

// File: tb/tb_dyn_phase_shift_ctrl.sv
// tb/tb_dyn_phase_shift_ctrl.sv - self-checking bench for dyn_phase_shift_ctrl

module tb_dyn_phase_shift_ctrl;

  localparam int STEP   = 1000;
  localparam int SETTLE = 12;
  localparam int TURN   = 360000;

  logic clk;
  logic rst, pwrdwn, psen, psincdec, lock;
  logic signed [31:0] shift;
  logic done, busy, err;

  logic psen_p, psen_n;
  logic signed [31:0] wp_shift, wn_shift;
  logic wp_done, wp_busy, wp_err, wn_done, wn_busy, wn_err;
  logic zero_bit, one_bit, zero_dir, one_dir;

  int tests = 0;
  int fails = 0;

  // reference model: time-based view of one step in flight
  int m_shift;
  int m_e0;
  bit m_active;
  bit m_err;
  int n;

  dyn_phase_shift_ctrl #(
    .STEP_1000(STEP), .SETTLE_CYCLES(SETTLE), .INIT_SHIFT_1000(0)
  ) dut (
    .clk(clk), .RST(rst), .PWRDWN(pwrdwn), .PSEN(psen), .PSINCDEC(psincdec),
    .lock_in(lock), .shift_1000(shift), .PSDONE(done), .busy(busy), .ps_err(err)
  );

  dyn_phase_shift_ctrl #(
    .STEP_1000(STEP), .SETTLE_CYCLES(1), .INIT_SHIFT_1000(359500)
  ) dut_wp (
    .clk(clk), .RST(rst), .PWRDWN(zero_bit), .PSEN(psen_p), .PSINCDEC(one_dir),
    .lock_in(one_bit), .shift_1000(wp_shift), .PSDONE(wp_done), .busy(wp_busy), .ps_err(wp_err)
  );

  dyn_phase_shift_ctrl #(
    .STEP_1000(STEP), .SETTLE_CYCLES(255), .INIT_SHIFT_1000(-359500)
  ) dut_wn (
    .clk(clk), .RST(rst), .PWRDWN(zero_bit), .PSEN(psen_n), .PSINCDEC(zero_dir),
    .lock_in(one_bit), .shift_1000(wn_shift), .PSDONE(wn_done), .busy(wn_busy), .ps_err(wn_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  function automatic int wrap_turn(input int v);
    if (v >= TURN) return v - TURN;
    if (v <= -TURN) return v + TURN;
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    tests++;
    assert (obs === 32'(exp)) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply the rules to the inputs seen at edge n.
  task automatic model_edge();
    m_err = 1'b0;
    if (rst) begin
      m_shift  = 0;
      m_active = 1'b0;
    end else if (pwrdwn) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (psen) m_err = 1'b1;
      if (n - m_e0 > SETTLE) m_active = 1'b0;
    end else if (psen) begin
      if (lock) begin
        m_shift  = wrap_turn(m_shift + (psincdec ? STEP : -STEP));
        m_e0     = n;
        m_active = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    model_edge();
    chk("shift", shift, m_shift);
    chk("busy", {31'd0, busy}, int'(m_active));
    chk("psdone", {31'd0, done}, int'(m_active && (n - m_e0 == SETTLE)));
    chk("ps_err", {31'd0, err}, int'(m_err));
  endtask

  task automatic idle_inputs();
    psen = 1'b0; psincdec = 1'b0; pwrdwn = 1'b0; rst = 1'b0;
  endtask

  initial begin
    int dcount;
    n = 0; m_shift = 0; m_e0 = -1000; m_active = 1'b0; m_err = 1'b0;
    zero_bit = 1'b0; one_bit = 1'b1; zero_dir = 1'b0; one_dir = 1'b1;
    psen_p = 1'b0; psen_n = 1'b0;
    idle_inputs();
    lock = 1'b1;

    // reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_shift", shift, 0);
    chk("wp_init", wp_shift, 359500);
    chk("wn_init", wn_shift, -359500);

    // single increment
    psen = 1'b1; psincdec = 1'b1;
    tick();
    psen = 1'b0;
    chk("inc_shift", shift, 1000);
    chk("inc_busy", {31'd0, busy}, 1);
    dcount = 0;
    repeat (11) begin tick(); dcount += int'(done); end
    chk("no_early_done", dcount, 0);
    tick();
    chk("done_at_e12", {31'd0, done}, 1);
    tick();
    chk("busy_off_e13", {31'd0, busy}, 0);

    // busy rejection at E0+5
    psen = 1'b1; psincdec = 1'b1;
    tick();
    psen = 1'b0;
    repeat (4) tick();
    psen = 1'b1; psincdec = 1'b0;
    tick();
    psen = 1'b0;
    chk("busy_rej_err", {31'd0, err}, 1);
    chk("busy_rej_shift", shift, 2000);
    dcount = 0;
    repeat (10) begin tick(); dcount += int'(done); end
    chk("single_done", dcount, 1);

    // no lock
    lock = 1'b0; psen = 1'b1; psincdec = 1'b1;
    tick();
    psen = 1'b0; lock = 1'b1;
    chk("nolock_err", {31'd0, err}, 1);
    chk("nolock_busy", {31'd0, busy}, 0);
    tick();

    // lock loss during settle does not abort
    psen = 1'b1; psincdec = 1'b0;
    tick();
    psen = 1'b0; lock = 1'b0;
    dcount = 0;
    repeat (13) begin tick(); dcount += int'(done); end
    lock = 1'b1;
    chk("lockloss_done", dcount, 1);

    // reset mid-step
    psen = 1'b1; psincdec = 1'b1;
    tick();
    psen = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_shift", shift, 0);
    dcount = 0;
    repeat (20) begin tick(); dcount += int'(done); end
    chk("midrst_nodone", dcount, 0);

    // power-down mid-step
    psen = 1'b1; psincdec = 1'b1;
    tick();
    psen = 1'b0;
    repeat (4) tick();
    pwrdwn = 1'b1; psen = 1'b1;
    tick();
    chk("pd_shift", shift, 1000);
    chk("pd_busy", {31'd0, busy}, 0);
    dcount = 0;
    repeat (20) begin tick(); dcount += int'(done) + int'(err); end
    chk("pd_quiet", dcount, 0);
    psen = 1'b0;

    // reset wins over power-down
    rst = 1'b1;
    tick();
    idle_inputs();
    chk("rst_over_pd", shift, 0);
    tick();

    // wrap upward, SETTLE_CYCLES=1
    psen_p = 1'b1;
    tick();
    psen_p = 1'b0;
    chk("wp_shift", wp_shift, 500);
    chk("wp_busy", {31'd0, wp_busy}, 1);
    chk("wp_done_e0", {31'd0, wp_done}, 0);
    tick();
    chk("wp_done_e1", {31'd0, wp_done}, 1);
    tick();
    chk("wp_done_e2", {31'd0, wp_done}, 0);
    chk("wp_idle", {31'd0, wp_busy}, 0);
    chk("wp_err", {31'd0, wp_err}, 0);

    // wrap downward, SETTLE_CYCLES=255
    psen_n = 1'b1;
    tick();
    psen_n = 1'b0;
    chk("wn_shift", wn_shift, -500);
    chk("wn_busy", {31'd0, wn_busy}, 1);
    repeat (254) tick();
    chk("wn_done_e254", {31'd0, wn_done}, 0);
    tick();
    chk("wn_done_e255", {31'd0, wn_done}, 1);
    tick();
    chk("wn_done_e256", {31'd0, wn_done}, 0);
    chk("wn_idle", {31'd0, wn_busy}, 0);
    chk("wn_err", {31'd0, wn_err}, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      psen     = ($urandom_range(0, 2) == 0);
      psincdec = $urandom_range(0, 1) == 1;
      lock     = ($urandom_range(0, 7) != 0);
      pwrdwn   = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
